// File: rtl/fede_skid.sv
`default_nettype none
// ============================================================================
//  Module   : fede_skid
//  Purpose  : Fetch-to-decode pipeline stage with valid/ready handshaking and
//             a 2-entry skid buffer. ready_f comes straight from a flop, so it
//             never depends combinationally on the decode-side stall. Supports
//             flush with NOP injection and a saturating flush counter.
//  Revision : 1.0  initial release
// ============================================================================
module fede_skid #(
  parameter int               XLEN      = 32,
  parameter int               ILEN      = 32,
  parameter logic [ILEN-1:0]  NOP_INSTR = 32'h00000013,
  parameter int               CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en_n,
  input  logic              valid_f,
  output logic              ready_f,
  input  logic [ILEN-1:0]   instrf,
  input  logic [XLEN-1:0]   pcf,
  input  logic [XLEN-1:0]   pc4f,
  output logic              valid_d,
  output logic [ILEN-1:0]   instrd,
  output logic [XLEN-1:0]   pcd,
  output logic [XLEN-1:0]   pc4d,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  // Skid register: holds the second entry when decode stalls while fetch
  // still delivers. It is never visible on the outputs directly.
  logic              r_skid_v;
  logic [ILEN-1:0]   r_skid_instr;
  logic [XLEN-1:0]   r_skid_pc;
  logic [XLEN-1:0]   r_skid_pc4;

  logic              w_accept;
  logic              w_consume;
  logic [1:0]        w_discard;
  logic [CNT_W:0]    w_cnt_sum;
  logic [CNT_W-1:0]  w_cnt_next;

  // ready_f is the inverse of a flop output, so the stall cannot reach it
  // through any combinational path.
  assign ready_f   = ~r_skid_v;
  assign w_accept  = valid_f & ready_f;
  assign w_consume = valid_d & ~en_n;

  // Entries thrown away by a flush: the main entry only if decode is not
  // taking it in that same cycle, plus whatever sits in the skid register.
  assign w_discard  = {1'b0, valid_d & ~w_consume} + {1'b0, r_skid_v};
  // One extra bit catches the carry; any carry means the counter saturates.
  assign w_cnt_sum  = {1'b0, flush_cnt} + (CNT_W+1)'(w_discard);
  assign w_cnt_next = w_cnt_sum[CNT_W] ? c_CNT_MAX : w_cnt_sum[CNT_W-1:0];

  // Main/skid occupancy update; reset beats flush, flush beats handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_d      <= 1'b0;
      instrd       <= NOP_INSTR;
      pcd          <= '0;
      pc4d         <= '0;
      r_skid_v     <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_skid_pc4   <= '0;
    end else if (clr) begin
      valid_d      <= 1'b0;
      instrd       <= NOP_INSTR;
      pcd          <= '0;
      pc4d         <= '0;
      r_skid_v     <= 1'b0;
    end else if (!valid_d) begin
      // Empty: the stall input is irrelevant, only an incoming entry matters.
      if (w_accept) begin
        valid_d <= 1'b1;
        instrd  <= instrf;
        pcd     <= pcf;
        pc4d    <= pc4f;
      end
    end else if (!r_skid_v) begin
      // One entry held in main.
      if (w_accept && w_consume) begin
        instrd <= instrf;
        pcd    <= pcf;
        pc4d   <= pc4f;
      end else if (w_accept) begin
        r_skid_v     <= 1'b1;
        r_skid_instr <= instrf;
        r_skid_pc    <= pcf;
        r_skid_pc4   <= pc4f;
      end else if (w_consume) begin
        valid_d <= 1'b0;
        instrd  <= NOP_INSTR;
        pcd     <= '0;
        pc4d    <= '0;
      end
    end else begin
      // Full: nothing can be accepted; the skid entry moves up on consume.
      if (w_consume) begin
        instrd   <= r_skid_instr;
        pcd      <= r_skid_pc;
        pc4d     <= r_skid_pc4;
        r_skid_v <= 1'b0;
      end
    end
  end

  // Flush counter: cleared by reset, saturating increment on each flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= '0;
    end else if (clr) begin
      flush_cnt <= w_cnt_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fede_skid.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fede_skid
//  Purpose  : Self-checking bench for fede_skid. Accepted entries go into a
//             scoreboard queue; a monitor pops and compares on every consume.
//             Directed checks cover reset, stall, flush and saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fede_skid;

  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int CNT_W = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst, clr, en_n, valid_f;
  logic             ready_f, valid_d;
  logic [ILEN-1:0]  instrf, instrd;
  logic [XLEN-1:0]  pcf, pc4f, pcd, pc4d;
  logic [CNT_W-1:0] flush_cnt;

  int   n_checks = 0;
  int   n_errors = 0;
  ent_t sb_q[$];

  fede_skid #(
    .XLEN(XLEN), .ILEN(ILEN), .NOP_INSTR(32'h00000013), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .en_n(en_n),
    .valid_f(valid_f), .ready_f(ready_f),
    .instrf(instrf), .pcf(pcf), .pc4f(pc4f),
    .valid_d(valid_d), .instrd(instrd), .pcd(pcd), .pc4d(pc4d),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return 32'h00000093 | (pc << 12);
  endfunction

  // Inputs change 2 time units after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic offer(input logic [31:0] pc);
    valid_f = 1'b1;
    pcf     = pc;
    pc4f    = pc + 32'd4;
    instrf  = mk_instr(pc);
  endtask

  task automatic idle_in();
    valid_f = 1'b0;
    pcf     = 32'hDEAD_BEEF;
    pc4f    = 32'hDEAD_BEEF;
    instrf  = 32'hDEAD_BEEF;
  endtask

  // Stimulus side of the scoreboard: record each entry fetch hands over.
  always @(negedge clk) begin
    if (!rst && !clr && valid_f && ready_f)
      sb_q.push_back('{instr: instrf, pc: pcf, pc4: pc4f});
  end

  // Monitor: every consume must present the oldest outstanding entry.
  always @(negedge clk) begin
    ent_t e;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (valid_d && !en_n) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_pc", {32'h0, pcd}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("sb_pc_pc4", {pc4d, pcd}, {e.pc4, e.pc});
          chk("sb_instr", {32'h0, instrd}, {32'h0, e.instr});
        end
      end
      if (clr) sb_q.delete();
    end
  end

  task automatic fill_full(input logic [31:0] pc0);
    en_n = 1'b1;
    offer(pc0);
    tick();
    offer(pc0 + 32'd4);
    tick();
    idle_in();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clr = 1'b0; en_n = 1'b0;
    idle_in();
    tick();
    tick();
    // Reset state
    chk("rst_valid_d", {63'h0, valid_d}, 64'd0);
    chk("rst_instrd",  {32'h0, instrd}, 64'h13);
    chk("rst_ready_f", {63'h0, ready_f}, 64'd1);
    chk("rst_pcd",     {32'h0, pcd}, 64'd0);
    chk("rst_cnt",     {62'h0, flush_cnt}, 64'd0);

    // Single fetch, one-cycle latency
    rst = 1'b0;
    valid_f = 1'b1; instrf = 32'h00A00093; pcf = 32'h100; pc4f = 32'h104;
    tick();
    chk("single_valid_d", {63'h0, valid_d}, 64'd1);
    chk("single_instrd",  {32'h0, instrd}, 64'h00A00093);
    chk("single_pcd",     {32'h0, pcd}, 64'h100);
    idle_in();
    tick();
    chk("single_drain_valid", {63'h0, valid_d}, 64'd0);
    chk("single_drain_nop",   {32'h0, instrd}, 64'h13);

    // Back-to-back stream with no stall
    for (int i = 0; i < 8; i++) begin
      offer(32'(i * 4));
      tick();
      chk("stream_valid_d", {63'h0, valid_d}, 64'd1);
      chk("stream_pcd",     {32'h0, pcd}, 64'(i * 4));
      chk("stream_ready_f", {63'h0, ready_f}, 64'd1);
    end
    idle_in();
    tick();
    chk("stream_end_valid", {63'h0, valid_d}, 64'd0);

    // Stall: A in main, B lands in skid, fetch offers junk while full
    offer(32'h20);
    tick();
    en_n = 1'b1;
    offer(32'h24);
    tick();
    chk("stall_pcd_a",   {32'h0, pcd}, 64'h20);
    chk("stall_ready_0", {63'h0, ready_f}, 64'd0);
    offer(32'h80);
    tick();
    chk("stall2_pcd",    {32'h0, pcd}, 64'h20);
    chk("stall2_ready",  {63'h0, ready_f}, 64'd0);
    tick();
    chk("stall3_pcd",    {32'h0, pcd}, 64'h20);
    en_n = 1'b0;
    idle_in();
    tick();
    chk("unstall_pcd_b", {32'h0, pcd}, 64'h24);
    chk("unstall_ready", {63'h0, ready_f}, 64'd1);
    tick();
    chk("unstall_empty", {63'h0, valid_d}, 64'd0);

    // Flush while full; the entry offered with clr must vanish
    rst = 1'b1; tick(); rst = 1'b0;
    fill_full(32'h30);
    chk("full_ready", {63'h0, ready_f}, 64'd0);
    clr = 1'b1; offer(32'h40);
    tick();
    chk("flush_valid_d", {63'h0, valid_d}, 64'd0);
    chk("flush_instrd",  {32'h0, instrd}, 64'h13);
    chk("flush_ready",   {63'h0, ready_f}, 64'd1);
    chk("flush_cnt_2",   {62'h0, flush_cnt}, 64'd2);
    clr = 1'b0; idle_in(); en_n = 1'b0;
    tick();
    chk("flush_no_0x40", {63'h0, valid_d}, 64'd0);

    // Flush concurrent with consume; offered entry while ready is dropped
    offer(32'h44);
    tick();
    clr = 1'b1; offer(32'h50);
    tick();
    chk("clrcons_cnt",   {62'h0, flush_cnt}, 64'd2);
    chk("clrcons_valid", {63'h0, valid_d}, 64'd0);
    chk("clrcons_pcd",   {32'h0, pcd}, 64'd0);
    clr = 1'b0; idle_in();
    tick();
    chk("clrcons_no_0x50", {63'h0, valid_d}, 64'd0);

    // Saturation with a 2-bit counter
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      fill_full(32'h200 + 32'(k * 16));
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("sat_cnt", {62'h0, flush_cnt}, (k == 0) ? 64'd2 : 64'd3);
    end

    // rst and clr together on a full stage leave the counter cleared
    fill_full(32'h300);
    rst = 1'b1; clr = 1'b1;
    tick();
    rst = 1'b0; clr = 1'b0;
    chk("rstclr_cnt",   {62'h0, flush_cnt}, 64'd0);
    chk("rstclr_valid", {63'h0, valid_d}, 64'd0);
    chk("rstclr_ready", {63'h0, ready_f}, 64'd1);

    // Flushing a single stalled entry counts one
    en_n = 1'b1;
    offer(32'h400);
    tick();
    idle_in();
    clr = 1'b1;
    tick();
    clr = 1'b0; en_n = 1'b0;
    chk("one_flush_cnt", {62'h0, flush_cnt}, 64'd1);

    tick();
    tick();
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fede_skid.md
Name: fede_skid

Overview:
- Parametrised successor to the IF/ID pipeline register.
- Adds valid/ready handshaking and a 2-entry skid buffer, so the fetch-side ready is registered and never depends combinationally on the decode-side stall.
- Supports flush with NOP injection and a saturating flushed-instruction counter.
- Sits between the fetch stage and the decode stage; driven by the hazard unit's stall (en_n) and flush (clr).

Parameters:
- XLEN, 32, width of the pc and pc+4 paths.
- ILEN, 32, instruction width.
- NOP_INSTR, 32'h00000013, value driven on instr_d when the stage is empty, flushed or reset (addi x0,x0,0).
- CNT_W, 16, width of the flush counter.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous flush; discards all held and incoming entries.
- en_n  in  1  active-low decode enable; 1 = decode stalled, output not consumed this cycle.
- valid_f  in  1  fetch presents an entry.
- ready_f  out  1  stage can accept an entry; registered.
- instrf  in  ILEN  fetched instruction.
- pcf  in  XLEN  fetch pc.
- pc4f  in  XLEN  fetch pc+4.
- valid_d  out  1  decode-side entry valid.
- instrd  out  ILEN  instruction to decode.
- pcd  out  XLEN  pc to decode.
- pc4d  out  XLEN  pc+4 to decode.
- flush_cnt  out  CNT_W  count of valid entries discarded by clr, saturating.

Behaviour:
- Storage:
  - main register (valid_d/instrd/pcd/pc4d) is the output.
  - skid register (skid_v/skid_instr/skid_pc/skid_pc4) is internal.
- Handshakes:
  - accept_in = valid_f & ready_f.
  - consume = valid_d & ~en_n.
  - ready_f = ~skid_v, from a flop, no combinational path from en_n.
- Occupancy states and transitions (no clr/rst):
  - EMPTY (valid_d=0, skid_v=0): accept_in -> ONE, main loads input.
  - ONE, accept_in & consume -> ONE: main loads input.
  - ONE, accept_in & ~consume -> FULL: skid loads input, main holds.
  - ONE, ~accept_in & consume -> EMPTY: main gets instrd=NOP_INSTR, pcd=0, pc4d=0.
  - ONE, neither -> ONE: hold.
  - FULL: ready_f=0, so no accept. consume -> ONE: main loads skid, skid_v<=0, skid data don't-care. ~consume -> FULL: hold.
- Ordering: strict FIFO, no entry lost or duplicated.
- Maximum 2 entries in flight. Latency is 1 cycle from accept to valid_d when the stage is empty.
- clr (priority over all handshake activity):
  - next cycle: valid_d=0, skid_v=0, ready_f=1, instrd=NOP_INSTR, pcd=0, pc4d=0.
  - the entry offered by fetch in the clr cycle is dropped, even if valid_f & ready_f.
  - a consume in the same cycle as clr still counts as consumed by decode and is not counted as flushed.
  - flush_cnt += (valid_d & ~consume) + skid_v, saturating at all-ones. It never wraps.
- rst: same register values as clr; additionally flush_cnt<=0. rst overrides clr, so a simultaneous rst+clr leaves flush_cnt=0.
- Reset values: valid_d=0, ready_f=1, instrd=NOP_INSTR, pcd=0, pc4d=0, flush_cnt=0.
- en_n when empty has no effect. valid_f when FULL is ignored, since ready_f=0.
- Data inputs are don't-care when valid_f=0. No X propagation from them into valid outputs.

Test Plan:
- Reset then single fetch:
  - stimulus: rst 1 cycle; valid_f=1, instrf=0x00A00093, pcf=0x100, pc4f=0x104, en_n=0.
  - response: after reset valid_d=0, instrd=0x13, ready_f=1. Next cycle valid_d=1, instrd=0x00A00093, pcd=0x100.
- Stream, no stall:
  - stimulus: 8 back-to-back entries, pc 0x0..0x1C.
  - response: valid_d continuous from cycle 1; pcd sequence 0x0,0x4,..,0x1C; ready_f stays 1.
- Stall into skid:
  - stimulus: entries A (pc 0x20) and B (pc 0x24) offered; en_n=1 for 3 cycles starting when A is in main.
  - response: B goes to skid, ready_f drops to 0 the following cycle, pcd holds 0x20.
  - after en_n=0: pcd=0x20, then 0x24, then ready_f=1.
- Flush while FULL:
  - stimulus: FULL with en_n=1; assert clr 1 cycle with valid_f=1, pcf=0x40.
  - response: next cycle valid_d=0, instrd=0x13, ready_f=1, flush_cnt=2; pc 0x40 is never seen on pcd.
- Flush with concurrent consume:
  - stimulus: ONE with en_n=0; clr=1 in the same cycle.
  - response: flush_cnt unchanged, valid_d=0 next cycle.
- Counter saturation and rst priority:
  - stimulus: CNT_W=2; 5 flushes of a FULL stage; then rst and clr together.
  - response: flush_cnt reads 2, then 3, then stays 3; after rst+clr flush_cnt=0.
